// File: rtl/red_pitaya_multi_nco_block_pkg.sv
// Shared constants and the quarter-wave sine table generator for the multi-channel NCO.
// Default widths live here so the top, the LUT and any wrapper agree on sizes.
package red_pitaya_multi_nco_block_pkg;

    localparam int NCH_DEF       = 4;
    localparam int LUTSZ_DEF     = 11;
    localparam int LUTBITS_DEF   = 17;
    localparam int PHASEBITS_DEF = 32;
    localparam int HARMBITS_DEF  = 3;
    localparam int PIPE_DEPTH    = 4;

    localparam logic [PHASEBITS_DEF-1:0] QSHIFT_DEF = 32'h4000_0000;

    // round((2^(lutbits-1)-1) * sin((idx+0.5)/2^lutsz * pi/2)), evaluated at elaboration.
    function automatic int lut_value(input int idx, input int lutsz, input int lutbits);
        real x;
        real term;
        real s;
        real amp;
        x    = (real'(idx) + 0.5) / real'(1 << lutsz) * 1.5707963267948966;
        term = x;
        s    = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            s    = s + term;
        end
        amp = real'((1 << (lutbits - 1)) - 1);
        return $rtoi(s * amp + 0.5);
    endfunction

endpackage

// File: rtl/red_pitaya_multi_nco_block_qsin_lut.sv
// Quarter-wave sine ROM with one registered read port, intended to map onto block RAM.
// Contents are computed at elaboration from the package generator.
module red_pitaya_qsin_lut
    import red_pitaya_multi_nco_block_pkg::*;
#(
    parameter int LUTSZ   = LUTSZ_DEF,
    parameter int LUTBITS = LUTBITS_DEF
) (
    input  logic               clk_i,
    input  logic [LUTSZ-1:0]   addr,
    output logic [LUTBITS-2:0] data
);

    logic [LUTBITS-2:0] rom [2**LUTSZ];

    for (genvar i = 0; i < 2**LUTSZ; i++) begin : g_rom
        localparam int VAL = lut_value(i, LUTSZ, LUTBITS);
        assign rom[i] = VAL[LUTBITS-2:0];
    end

    // No reset on the read register so it can sit inside the RAM primitive.
    always_ff @(posedge clk_i) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/red_pitaya_multi_nco_block.sv
// Multi-channel quadrature NCO: one shared phase accumulator, per-channel offset and
// harmonic multiplier, phase-continuous frequency updates via a pending register.
module red_pitaya_multi_nco_block
    import red_pitaya_multi_nco_block_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int LUTSZ     = LUTSZ_DEF,
    parameter int LUTBITS   = LUTBITS_DEF,
    parameter int PHASEBITS = PHASEBITS_DEF,
    parameter int HARMBITS  = HARMBITS_DEF
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     on,
    input  logic                     sync_i,
    input  logic [PHASEBITS-1:0]     freq_i,
    input  logic                     freq_we_i,
    input  logic                     upd_at_wrap_i,
    output logic                     freq_busy_o,
    input  logic [NCH*PHASEBITS-1:0] offset_i,
    input  logic [NCH*HARMBITS-1:0]  harm_i,
    output logic [NCH*LUTBITS-1:0]   sin_o,
    output logic [NCH*LUTBITS-1:0]   cos_o,
    output logic                     valid_o,
    output logic [PHASEBITS-1:0]     phase_o
);

    localparam logic [PHASEBITS-1:0] QSHIFT = {{(PHASEBITS-1){1'b0}}, 1'b1} << (PHASEBITS - 2);

    function automatic logic signed [LUTBITS-1:0] apply_sign(input logic [LUTBITS-2:0] mag,
                                                            input logic neg);
        logic signed [LUTBITS-1:0] m;
        m = {1'b0, mag};
        return neg ? -m : m;
    endfunction

    logic [PHASEBITS-1:0] acc;
    logic [PHASEBITS-1:0] freq_act;
    logic [PHASEBITS-1:0] pending;
    logic                 busy;
    logic [PHASEBITS:0]   sum;
    logic                 wrap;
    logic                 apply;

    assign sum   = {1'b0, acc} + {1'b0, freq_act};
    assign wrap  = sum[PHASEBITS];
    // A sync pulse resets the phase, so it is treated as a wrap for deferred updates.
    assign apply = busy && (!upd_at_wrap_i || (on && (sync_i || wrap)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc      <= '0;
            freq_act <= '0;
            pending  <= '0;
            busy     <= 1'b0;
        end else begin
            if (!on || sync_i) acc <= '0;
            else               acc <= sum[PHASEBITS-1:0];
            if (apply) freq_act <= pending;
            if (freq_we_i) begin
                pending <= freq_i;
                busy    <= 1'b1;
            end else if (apply) begin
                busy    <= 1'b0;
            end
        end
    end

    assign freq_busy_o = busy;

    logic [PIPE_DEPTH-1:0] vld;
    logic [PHASEBITS-1:0]  ph_dly [PIPE_DEPTH];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) ph_dly[i] <= '0;
        end else if (!on) begin
            vld <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) ph_dly[i] <= '0;
        end else begin
            vld       <= {vld[PIPE_DEPTH-2:0], 1'b1};
            ph_dly[0] <= acc;
            for (int i = 1; i < PIPE_DEPTH; i++) ph_dly[i] <= ph_dly[i-1];
        end
    end

    assign valid_o = vld[PIPE_DEPTH-1];
    assign phase_o = ph_dly[PIPE_DEPTH-1];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [HARMBITS-1:0]       harm;
        logic [PHASEBITS-1:0]      prod;
        logic [PHASEBITS-1:0]      ph1;
        logic [PHASEBITS-1:0]      ph1_c;
        logic                      mute1, mute2, mute3;
        logic [LUTSZ-1:0]          idx_s, idx_c;
        logic [1:0]                sgn2, sgn3;
        logic [LUTBITS-2:0]        lut_s, lut_c;
        logic signed [LUTBITS-1:0] sin_r, cos_r;

        assign harm  = harm_i[k*HARMBITS +: HARMBITS];
        assign prod  = acc * {{(PHASEBITS-HARMBITS){1'b0}}, harm};
        assign ph1_c = ph1 + QSHIFT;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                ph1   <= '0;
                mute1 <= 1'b1;
                idx_s <= '0;
                idx_c <= '0;
                sgn2  <= '0;
                mute2 <= 1'b1;
                sgn3  <= '0;
                mute3 <= 1'b1;
            end else begin
                ph1   <= prod + offset_i[k*PHASEBITS +: PHASEBITS];
                mute1 <= (harm == '0);
                // Second quadrant mirrors the first: inverting the index walks the table backwards.
                idx_s <= ph1[PHASEBITS-3 -: LUTSZ] ^ {LUTSZ{ph1[PHASEBITS-2]}};
                idx_c <= ph1_c[PHASEBITS-3 -: LUTSZ] ^ {LUTSZ{ph1_c[PHASEBITS-2]}};
                sgn2  <= {ph1_c[PHASEBITS-1], ph1[PHASEBITS-1]};
                mute2 <= mute1;
                sgn3  <= sgn2;
                mute3 <= mute2;
            end
        end

        red_pitaya_qsin_lut #(.LUTSZ(LUTSZ), .LUTBITS(LUTBITS)) u_lut_sin (
            .clk_i (clk_i),
            .addr  (idx_s),
            .data  (lut_s)
        );

        red_pitaya_qsin_lut #(.LUTSZ(LUTSZ), .LUTBITS(LUTBITS)) u_lut_cos (
            .clk_i (clk_i),
            .addr  (idx_c),
            .data  (lut_c)
        );

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                sin_r <= '0;
                cos_r <= '0;
            end else if (!on || !vld[PIPE_DEPTH-2] || mute3) begin
                sin_r <= '0;
                cos_r <= '0;
            end else begin
                sin_r <= apply_sign(lut_s, sgn3[0]);
                cos_r <= apply_sign(lut_c, sgn3[1]);
            end
        end

        assign sin_o[k*LUTBITS +: LUTBITS] = sin_r;
        assign cos_o[k*LUTBITS +: LUTBITS] = cos_r;
    end

endmodule

// File: tb/tb_red_pitaya_multi_nco_block.sv
// Directed bench for the multi-channel NCO: quadrant-aligned phases give hand-known sine values.
`timescale 1ns/1ps
module tb_red_pitaya_multi_nco_block;

    localparam int NCH = 4;
    localparam int LB  = 17;
    localparam int PB  = 32;
    localparam int HB  = 3;

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b0;
    logic              on = 1'b0;
    logic              sync_i = 1'b0;
    logic [PB-1:0]     freq_i = '0;
    logic              freq_we_i = 1'b0;
    logic              upd_at_wrap_i = 1'b0;
    logic              freq_busy_o;
    logic [NCH*PB-1:0] offset_i;
    logic [NCH*HB-1:0] harm_i;
    logic [NCH*LB-1:0] sin_o;
    logic [NCH*LB-1:0] cos_o;
    logic              valid_o;
    logic [PB-1:0]     phase_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Output at phase q*2^30 for q = 0..3 (half-step LUT: 25 = first entry, 65535 = last).
    int sq[4]     = '{25, 65535, -25, -65535};
    int harm_k[4] = '{1, 2, 0, 3};
    int offq_k[4] = '{0, 2, 0, 1};

    always #5 clk_i = ~clk_i;

    red_pitaya_multi_nco_block dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .on            (on),
        .sync_i        (sync_i),
        .freq_i        (freq_i),
        .freq_we_i     (freq_we_i),
        .upd_at_wrap_i (upd_at_wrap_i),
        .freq_busy_o   (freq_busy_o),
        .offset_i      (offset_i),
        .harm_i        (harm_i),
        .sin_o         (sin_o),
        .cos_o         (cos_o),
        .valid_o       (valid_o),
        .phase_o       (phase_o)
    );

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic signed [63:0] sin_ch(input int k);
        logic signed [LB-1:0] s;
        s = sin_o[k*LB +: LB];
        return s;
    endfunction

    function automatic logic signed [63:0] cos_ch(input int k);
        logic signed [LB-1:0] c;
        c = cos_o[k*LB +: LB];
        return c;
    endfunction

    // Accumulator value after the t-th edge following the sync in the update sequence.
    function automatic logic [PB-1:0] exp_acc(input int u);
        logic [PB-1:0] v;
        if (u <= 15)      v = PB'(u) << 28;
        else if (u <= 24) v = PB'(u - 16) << 29;
        else              v = PB'(u - 24) << 28;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        logic [PB-1:0] ep;
        int            q;
        logic          eb;

        offset_i = {32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        harm_i   = {3'd3, 3'd0, 3'd2, 3'd1};

        step(2);
        check("rst_valid", valid_o, 0);
        check("rst_busy", freq_busy_o, 0);
        check("rst_phase", phase_o, 0);
        check("rst_sin0", sin_ch(0), 0);
        check("rst_cos0", cos_ch(0), 0);
        rstn_i = 1'b1;

        // Load 2^30 while stopped; immediate apply.
        freq_i = 32'h4000_0000;
        freq_we_i = 1'b1;
        step(1);
        check("load_busy_hi", freq_busy_o, 1);
        freq_we_i = 1'b0;
        step(1);
        check("load_busy_lo", freq_busy_o, 0);
        on = 1'b1;

        for (int t = 1; t <= 11; t++) begin
            step(1);
            if (t < 4) begin
                check($sformatf("fill_valid_t%0d", t), valid_o, 0);
            end else begin
                ep = PB'(t - 4) << 30;
                check($sformatf("run_valid_t%0d", t), valid_o, 1);
                check($sformatf("run_phase_t%0d", t), phase_o, ep);
                for (int k = 0; k < NCH; k++) begin
                    q = (harm_k[k] * (t - 4) + offq_k[k]) % 4;
                    check($sformatf("sin%0d_t%0d", k, t), sin_ch(k),
                          harm_k[k] == 0 ? 0 : sq[q]);
                    check($sformatf("cos%0d_t%0d", k, t), cos_ch(k),
                          harm_k[k] == 0 ? 0 : sq[(q + 1) % 4]);
                end
            end
        end

        // Set 2^28 with a sync so the accumulator restarts from a known zero.
        freq_i = 32'h1000_0000;
        freq_we_i = 1'b1;
        step(1);
        freq_we_i = 1'b0;
        sync_i = 1'b1;
        step(1);
        sync_i = 1'b0;
        check("upd_busy_t0", freq_busy_o, 0);
        for (int t = 1; t <= 30; t++) begin
            step(1);
            eb = ((t >= 6) && (t <= 15)) || (t == 23);
            check($sformatf("upd_busy_t%0d", t), freq_busy_o, eb);
            if (t >= 4) check($sformatf("upd_phase_t%0d", t), phase_o, exp_acc(t - 4));
            if (t == 5) begin
                freq_i = 32'h2000_0000;
                freq_we_i = 1'b1;
                upd_at_wrap_i = 1'b1;
            end
            if (t == 6) freq_we_i = 1'b0;
            if (t == 22) begin
                freq_i = 32'h1000_0000;
                freq_we_i = 1'b1;
                upd_at_wrap_i = 1'b0;
            end
            if (t == 23) freq_we_i = 1'b0;
        end

        // Second write lands in the apply cycle of the first.
        freq_i = 32'h0400_0000;
        freq_we_i = 1'b1;
        step(1);
        check("dbl_busy_a", freq_busy_o, 1);
        freq_i = 32'h0800_0000;
        sync_i = 1'b1;
        step(1);
        freq_we_i = 1'b0;
        sync_i = 1'b0;
        check("dbl_busy_b", freq_busy_o, 1);
        step(1);
        check("dbl_busy_c", freq_busy_o, 0);
        step(2);
        step(1);
        check("sync_phase0", phase_o, 0);
        check("sync_sin0", sin_ch(0), 25);
        step(1);
        check("dbl_phase_c", phase_o, 32'h0400_0000);
        step(1);
        check("dbl_phase_d", phase_o, 32'h0C00_0000);
        step(1);
        check("dbl_phase_e", phase_o, 32'h1400_0000);

        // One-cycle stop.
        on = 1'b0;
        step(1);
        check("off_valid", valid_o, 0);
        check("off_phase", phase_o, 0);
        check("off_sin0", sin_ch(0), 0);
        check("off_cos0", cos_ch(0), 0);
        check("off_sin1", sin_ch(1), 0);
        check("off_cos3", cos_ch(3), 0);
        on = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            step(1);
            if (t < 4) begin
                check($sformatf("resume_valid_t%0d", t), valid_o, 0);
                check($sformatf("resume_sin0_t%0d", t), sin_ch(0), 0);
            end else if (t == 4) begin
                check("resume_valid_t4", valid_o, 1);
                check("resume_phase_t4", phase_o, 0);
                check("resume_sin0_t4", sin_ch(0), 25);
                check("resume_cos0_t4", cos_ch(0), 65535);
            end else begin
                check("resume_phase_t5", phase_o, 32'h0800_0000);
            end
        end

        // Asynchronous reset in the middle of a cycle with an update pending.
        freq_i = 32'h0100_0000;
        freq_we_i = 1'b1;
        upd_at_wrap_i = 1'b1;
        step(1);
        check("pre_rst_busy", freq_busy_o, 1);
        freq_we_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        check("mid_rst_busy", freq_busy_o, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_phase", phase_o, 0);
        check("mid_rst_sin0", sin_ch(0), 0);
        check("mid_rst_cos0", cos_ch(0), 0);
        check("mid_rst_sin3", sin_ch(3), 0);
        step(1);
        rstn_i = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            step(1);
            check($sformatf("post_rst_busy_t%0d", t), freq_busy_o, 0);
            if (t < 4) begin
                check($sformatf("post_rst_valid_t%0d", t), valid_o, 0);
            end else begin
                check($sformatf("post_rst_valid_t%0d", t), valid_o, 1);
                check($sformatf("post_rst_phase_t%0d", t), phase_o, 0);
                check($sformatf("post_rst_sin0_t%0d", t), sin_ch(0), 25);
                check($sformatf("post_rst_cos0_t%0d", t), cos_ch(0), 65535);
                check($sformatf("post_rst_sin2_t%0d", t), sin_ch(2), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
